// File: rtl/fetch_unit_if.sv
// Instruction-memory read port: request/address out, data/ack back.
interface fetch_unit_if;
    localparam int unsigned AW = 32;
    localparam int unsigned DW = 32;

    logic          imem_req;
    logic [AW-1:0] imem_addr;
    logic [DW-1:0] imem_rdata;
    logic          imem_ack;

    modport master (output imem_req, output imem_addr, input imem_rdata, input imem_ack);
    modport slave  (input imem_req, input imem_addr, output imem_rdata, output imem_ack);
endinterface

// File: rtl/fetch_unit.sv
// Single-outstanding instruction fetch unit with stall hold and branch redirect.
// Optional macro FETCH_MISALIGN_CHK_EN: halt with a sticky flag on misaligned branch targets.
module fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic                clk,
    input  logic                rst,
    fetch_unit_if.master        imem,
    input  logic                PCsrc,
    input  logic [31:0]         ImmOp,
    input  logic                stall,
    output logic [31:0]         PC,
    output logic [31:0]         instr,
    output logic                instr_valid,
    output logic [31:0]         instr_count,
    output logic                misalign_err
);
    localparam int unsigned XLEN = 32;

`ifdef FETCH_MISALIGN_CHK_EN
    typedef enum logic [1:0] {S_IDLE, S_REQ, S_VALID, S_HALT} state_t;
`else
    typedef enum logic [1:0] {S_IDLE, S_REQ, S_VALID} state_t;
`endif

    state_t          r_state;
    state_t          w_state_nxt;
    logic [XLEN-1:0] r_pc;
    logic [XLEN-1:0] w_pc_nxt;
    logic [XLEN-1:0] w_target;
    logic [XLEN-1:0] r_instr;
    logic [XLEN-1:0] r_count;
    logic            r_instr_valid;
    logic            r_imem_req;
    logic            w_capture;
    logic            w_accept;
`ifdef FETCH_MISALIGN_CHK_EN
    logic            w_misalign_set;
    logic            r_misalign;
`endif

    assign w_target = r_pc + ImmOp;

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state, capture/accept strobes and next PC
    always_comb begin
        w_state_nxt = r_state;
        w_pc_nxt    = r_pc;
        w_capture   = 1'b0;
        w_accept    = 1'b0;
`ifdef FETCH_MISALIGN_CHK_EN
        w_misalign_set = 1'b0;
`endif
        case (r_state)
            S_IDLE: w_state_nxt = S_REQ;
            S_REQ: begin
                if (imem.imem_ack) begin
                    w_capture   = 1'b1;
                    w_state_nxt = S_VALID;
                end
            end
            S_VALID: begin
                if (!stall) begin
                    w_accept    = 1'b1;
                    w_state_nxt = S_REQ;
                    if (PCsrc) begin
`ifdef FETCH_MISALIGN_CHK_EN
                        w_pc_nxt = w_target;
                        if (w_target[1:0] != 2'b00) begin
                            w_misalign_set = 1'b1;
                            w_state_nxt    = S_HALT;
                        end
`else
                        w_pc_nxt = w_target & ~XLEN'(3);
`endif
                    end else begin
                        w_pc_nxt = r_pc + XLEN'(4);
                    end
                end
            end
`ifdef FETCH_MISALIGN_CHK_EN
            S_HALT: w_state_nxt = S_HALT;
`endif
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Request is registered off the next state so it drops with the state change
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_imem_req <= 1'b0;
        end else begin
            r_imem_req <= (w_state_nxt == S_REQ);
        end
    end

    // Datapath: PC, instruction buffer, accept counter
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_pc          <= RESET_PC;
            r_instr       <= '0;
            r_instr_valid <= 1'b0;
            r_count       <= '0;
        end else begin
            if (w_capture) begin
                r_instr       <= imem.imem_rdata;
                r_instr_valid <= 1'b1;
            end
            if (w_accept) begin
                r_pc          <= w_pc_nxt;
                r_instr_valid <= 1'b0;
                r_count       <= r_count + XLEN'(1);
            end
        end
    end

`ifdef FETCH_MISALIGN_CHK_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_misalign <= 1'b0;
        end else if (w_misalign_set) begin
            r_misalign <= 1'b1;
        end
    end
    assign misalign_err = r_misalign;
`else
    assign misalign_err = 1'b0;
`endif

    assign imem.imem_req  = r_imem_req;
    assign imem.imem_addr = r_pc;
    assign PC             = r_pc;
    assign instr          = r_instr;
    assign instr_valid    = r_instr_valid;
    assign instr_count    = r_count;
endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: cycle table plus hand sequences for delayed ack, reset abort and PC wrap.
module tb_fetch_unit;
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    fetch_unit_if bus0();
    fetch_unit_if bus1();

    logic        PCsrc;
    logic        stall;
    logic [31:0] ImmOp;
    logic [31:0] pc0, instr0, cnt0;
    logic        v0, err0;
    logic [31:0] pc1, instr1, cnt1;
    logic        v1, err1;

    fetch_unit #(.RESET_PC(32'h0000_0000)) dut (
        .clk(clk), .rst(rst), .imem(bus0),
        .PCsrc(PCsrc), .ImmOp(ImmOp), .stall(stall),
        .PC(pc0), .instr(instr0), .instr_valid(v0),
        .instr_count(cnt0), .misalign_err(err0)
    );

    // Second instance at the top of the address space with a zero-latency memory
    fetch_unit #(.RESET_PC(32'hFFFF_FFFC)) dut_wrap (
        .clk(clk), .rst(rst), .imem(bus1),
        .PCsrc(1'b0), .ImmOp(32'h0), .stall(1'b0),
        .PC(pc1), .instr(instr1), .instr_valid(v1),
        .instr_count(cnt1), .misalign_err(err1)
    );
    assign bus1.imem_ack   = bus1.imem_req;
    assign bus1.imem_rdata = ~bus1.imem_addr;

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic        pcsrc;
        logic [31:0] imm;
        logic        stall;
        logic        ack;
        logic [31:0] rdata;
        logic        e_req;
        logic [31:0] e_pc;
        logic        e_valid;
        logic [31:0] e_instr;
        logic [31:0] e_cnt;
        logic        e_err;
    } vec_t;

    vec_t vecs[$];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%h required=%h", nm, act, exp);
        end
    endtask

    task automatic add(input logic pcsrc, input logic [31:0] imm, input logic stl,
                       input logic ack, input logic [31:0] rdata,
                       input logic e_req, input logic [31:0] e_pc, input logic e_valid,
                       input logic [31:0] e_instr, input logic [31:0] e_cnt, input logic e_err);
        vec_t t;
        t.pcsrc = pcsrc; t.imm = imm; t.stall = stl; t.ack = ack; t.rdata = rdata;
        t.e_req = e_req; t.e_pc = e_pc; t.e_valid = e_valid;
        t.e_instr = e_instr; t.e_cnt = e_cnt; t.e_err = e_err;
        vecs.push_back(t);
    endtask

    task automatic apply(input vec_t t, input int idx);
        PCsrc = t.pcsrc; ImmOp = t.imm; stall = t.stall;
        bus0.imem_ack = t.ack; bus0.imem_rdata = t.rdata;
        @(posedge clk); #1;
        bus0.imem_ack = 1'b0;
        chk($sformatf("v%0d.req", idx),   32'(bus0.imem_req), 32'(t.e_req));
        chk($sformatf("v%0d.addr", idx),  bus0.imem_addr,     t.e_pc);
        chk($sformatf("v%0d.pc", idx),    pc0,                t.e_pc);
        chk($sformatf("v%0d.valid", idx), 32'(v0),            32'(t.e_valid));
        chk($sformatf("v%0d.instr", idx), instr0,             t.e_instr);
        chk($sformatf("v%0d.count", idx), cnt0,               t.e_cnt);
        chk($sformatf("v%0d.err", idx),   32'(err0),          32'(t.e_err));
    endtask

    task automatic tick;
        @(posedge clk); #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        // pcsrc imm stall ack rdata | req pc valid instr count err
        add(0, 32'h0,        0, 0, 32'h0,        1, 32'h00, 0, 32'h00, 0, 0);
        add(0, 32'h0,        0, 1, 32'hA0,       0, 32'h00, 1, 32'hA0, 0, 0);
        add(0, 32'h0,        0, 0, 32'h0,        1, 32'h04, 0, 32'hA0, 1, 0);
        add(0, 32'h0,        0, 1, 32'hA1,       0, 32'h04, 1, 32'hA1, 1, 0);
        add(0, 32'h0,        0, 0, 32'h0,        1, 32'h08, 0, 32'hA1, 2, 0);
        add(0, 32'h0,        0, 1, 32'hA2,       0, 32'h08, 1, 32'hA2, 2, 0);
        add(0, 32'h0,        0, 0, 32'h0,        1, 32'h0C, 0, 32'hA2, 3, 0);
        add(0, 32'h0,        0, 1, 32'hA3,       0, 32'h0C, 1, 32'hA3, 3, 0);
        add(0, 32'h0,        0, 0, 32'h0,        1, 32'h10, 0, 32'hA3, 4, 0);
        add(0, 32'h0,        0, 1, 32'hA4,       0, 32'h10, 1, 32'hA4, 4, 0);
        add(1, 32'hFFFF_FFF8,0, 0, 32'h0,        1, 32'h08, 0, 32'hA4, 5, 0);
        add(0, 32'h0,        0, 1, 32'hA5,       0, 32'h08, 1, 32'hA5, 5, 0);
        add(1, 32'h8,        0, 0, 32'h0,        1, 32'h10, 0, 32'hA5, 6, 0);
        add(0, 32'h0,        0, 1, 32'hA6,       0, 32'h10, 1, 32'hA6, 6, 0);
        add(1, 32'h20,       0, 0, 32'h0,        1, 32'h30, 0, 32'hA6, 7, 0);
        add(0, 32'h0,        0, 1, 32'hA7,       0, 32'h30, 1, 32'hA7, 7, 0);
        add(0, 32'h0,        1, 1, 32'hDEADBEEF, 0, 32'h30, 1, 32'hA7, 7, 0);
        add(0, 32'h0,        1, 0, 32'h0,        0, 32'h30, 1, 32'hA7, 7, 0);
        add(0, 32'h0,        1, 1, 32'hDEADBEEF, 0, 32'h30, 1, 32'hA7, 7, 0);
        add(1, 32'h40,       1, 0, 32'h0,        0, 32'h30, 1, 32'hA7, 7, 0);
        add(0, 32'h0,        1, 1, 32'hDEADBEEF, 0, 32'h30, 1, 32'hA7, 7, 0);
        add(0, 32'h0,        0, 0, 32'h0,        1, 32'h34, 0, 32'hA7, 8, 0);
        add(0, 32'h0,        1, 0, 32'h0,        1, 32'h34, 0, 32'hA7, 8, 0);
        add(0, 32'h0,        1, 1, 32'hA8,       0, 32'h34, 1, 32'hA8, 8, 0);
        add(0, 32'h0,        0, 0, 32'h0,        1, 32'h38, 0, 32'hA8, 9, 0);
        add(0, 32'h0,        0, 1, 32'hA9,       0, 32'h38, 1, 32'hA9, 9, 0);
        add(1, 32'hC8,       0, 0, 32'h0,        1, 32'h100, 0, 32'hA9, 10, 0);
        add(0, 32'h0,        0, 1, 32'hAA,       0, 32'h100, 1, 32'hAA, 10, 0);
`ifdef FETCH_MISALIGN_CHK_EN
        add(1, 32'h2,        0, 0, 32'h0,        0, 32'h102, 0, 32'hAA, 11, 1);
        add(0, 32'h0,        0, 1, 32'hAB,       0, 32'h102, 0, 32'hAA, 11, 1);
        add(0, 32'h0,        0, 0, 32'h0,        0, 32'h102, 0, 32'hAA, 11, 1);
`else
        add(1, 32'h2,        0, 0, 32'h0,        1, 32'h100, 0, 32'hAA, 11, 0);
        add(0, 32'h0,        0, 1, 32'hAB,       0, 32'h100, 1, 32'hAB, 11, 0);
        add(0, 32'h0,        0, 0, 32'h0,        1, 32'h104, 0, 32'hAB, 12, 0);
`endif

        rst = 1'b1; PCsrc = 1'b0; ImmOp = '0; stall = 1'b0;
        bus0.imem_ack = 1'b0; bus0.imem_rdata = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst.req",   32'(bus0.imem_req), 32'd0);
        chk("rst.pc",    pc0,                32'h0);
        chk("rst.valid", 32'(v0),            32'd0);
        chk("rst.instr", instr0,             32'h0);
        chk("rst.count", cnt0,               32'h0);
        chk("rst.err",   32'(err0),          32'd0);
        chk("rst.pc1",   pc1,                32'hFFFF_FFFC);
        rst = 1'b0;

        for (int i = 0; i < vecs.size(); i++) apply(vecs[i], i);

        // Ack three cycles late: request and address hold, capture on the ack edge
        stall = 1'b0; PCsrc = 1'b0; ImmOp = '0; bus0.imem_ack = 1'b0;
        rst = 1'b1; tick(); rst = 1'b0;
        for (int k = 1; k <= 4; k++) begin
            tick();
            chk($sformatf("dly.req%0d", k),  32'(bus0.imem_req), 32'd1);
            chk($sformatf("dly.addr%0d", k), bus0.imem_addr,     32'h0);
            chk($sformatf("dly.valid%0d", k), 32'(v0),           32'd0);
        end
        bus0.imem_ack = 1'b1; bus0.imem_rdata = 32'hC0DE_0001;
        tick();
        bus0.imem_ack = 1'b0;
        chk("dly.cap_valid", 32'(v0), 32'd1);
        chk("dly.cap_instr", instr0,  32'hC0DE_0001);
        chk("dly.cap_req",   32'(bus0.imem_req), 32'd0);
        tick();
        chk("dly.acc_pc", pc0, 32'h4);
        chk("dly.acc_cnt", cnt0, 32'h1);

        // Reset mid-request: abandon immediately, late ack must not be captured
        #2 rst = 1'b1;
        #1;
        chk("abort.pc",    pc0, 32'h0);
        chk("abort.req",   32'(bus0.imem_req), 32'd0);
        chk("abort.count", cnt0, 32'h0);
        bus0.imem_ack = 1'b1; bus0.imem_rdata = 32'hBAD0_BAD0;
        @(posedge clk); #1;
        chk("abort.instr_rst", instr0, 32'h0);
        rst = 1'b0;
        tick();
        bus0.imem_ack = 1'b0;
        chk("abort.late_valid", 32'(v0), 32'd0);
        chk("abort.late_instr", instr0,  32'h0);
        chk("abort.late_req",   32'(bus0.imem_req), 32'd1);
        tick();
        chk("abort.still_valid", 32'(v0), 32'd0);
        chk("abort.still_pc",    pc0,     32'h0);

        // PC wrap from the top of the address space
        rst = 1'b1; tick();
        chk("wrap.rst_addr", bus1.imem_addr, 32'hFFFF_FFFC);
        rst = 1'b0;
        tick();
        chk("wrap.req0",  32'(bus1.imem_req), 32'd1);
        chk("wrap.addr0", bus1.imem_addr,     32'hFFFF_FFFC);
        tick();
        chk("wrap.valid", 32'(v1),  32'd1);
        chk("wrap.instr", instr1,   32'h0000_0003);
        tick();
        chk("wrap.req1",  32'(bus1.imem_req), 32'd1);
        chk("wrap.addr1", bus1.imem_addr,     32'h0000_0000);
        chk("wrap.pc1",   pc1,                32'h0000_0000);
        chk("wrap.cnt1",  cnt1,               32'h1);
        chk("wrap.err1",  32'(err1),          32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 The block SHALL have parameter RESET_PC, default 32'h0000_0000, giving the first fetch address after reset.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst  input  1  asynchronous, active-high reset.
REQ-004 PCsrc  input  1  branch-taken from decode; sampled only on instruction accept.
REQ-005 ImmOp  input  32  sign-extended branch offset from decode, two's complement.
REQ-006 stall  input  1  consumer not ready; holds current instruction.
REQ-007 imem_req  output  1  instruction memory read request.
REQ-008 imem_addr  output  32  read address; equals PC.
REQ-009 imem_rdata  input  32  read data; valid only when imem_ack=1.
REQ-010 imem_ack  input  1  read completion, single-cycle pulse, any latency >=0 cycles after request.
REQ-011 PC  output  32  address of instruction currently fetched/presented.
REQ-012 instr  output  32  registered instruction word to decode.
REQ-013 instr_valid  output  1  instr holds a fetched word not yet accepted.
REQ-014 instr_count  output  32  count of accepted instructions.
REQ-015 misalign_err  output  1  sticky misaligned-target flag (see Configuration).

Function
REQ-016 FSM states SHALL be IDLE, REQ, VALID, HALT; HALT reachable only with FETCH_MISALIGN_CHK_EN.
REQ-017 IDLE: imem_req=0; unconditional transition to REQ on next edge.
REQ-018 REQ: imem_req=1, imem_addr=PC; ack in same cycle as request is legal.
REQ-019 REQ with imem_ack=1: instr<=imem_rdata, instr_valid<=1, state->VALID on that edge; minimum latency request-to-instr_valid = 1 cycle.
REQ-020 imem_ack outside REQ SHALL be ignored; imem_rdata never captured outside REQ.
REQ-021 stall SHALL be ignored in IDLE and REQ.
REQ-022 Accept = VALID and stall=0; on accept: PC<=PC+ImmOp if PCsrc=1 else PC+4, instr_valid<=0, instr_count<=instr_count+1, state->REQ.
REQ-023 VALID with stall=1: PC, instr, instr_valid, instr_count SHALL hold unchanged for any number of cycles.
REQ-024 Address arithmetic SHALL be 32-bit modulo 2^32; PC 32'hFFFF_FFFC+4 wraps to 32'h0000_0000.
REQ-025 instr_count SHALL wrap 32'hFFFF_FFFF->0 without flag.
REQ-026 instr SHALL retain last captured value while instr_valid=0.
REQ-027 Sustained throughput with zero-latency memory and no stall SHALL be one instruction per 2 cycles.

Reset
REQ-028 While rst=1: state=IDLE, PC=RESET_PC, instr=0, instr_valid=0, instr_count=0, misalign_err=0, imem_req=0.
REQ-029 rst asserted mid-request (REQ) or mid-stall (VALID) SHALL abandon the transaction immediately; an imem_ack arriving during or after reset for the abandoned request before the next REQ state is ignored.
REQ-030 First imem_req after reset release SHALL assert in the second cycle after the first clock edge with rst=0 (IDLE one cycle).

Configuration
REQ-031 Macro FETCH_MISALIGN_CHK_EN controls branch-target alignment checking.
REQ-032 Defined: on accept with PCsrc=1 and (PC+ImmOp)[1:0]!=0, misalign_err<=1, PC<=that target unmodified, state->HALT; HALT: imem_req=0, instr_valid=0, exit only by reset.
REQ-033 Not defined: branch target bits [1:0] forced to 2'b00, misalign_err tied 0, HALT state absent.

Verification
REQ-034 Reset release, RESET_PC=0, ack same cycle as req, stall=0, PCsrc=0 -> imem_addr sequence 0,4,8,12; instr_valid every other cycle; instr_count=4 after 4 accepts.
REQ-035 PC=32'h10, instr_valid=1, PCsrc=1, ImmOp=32'hFFFF_FFF8 -> next imem_addr=32'h08; ImmOp=32'h20 -> 32'h30.
REQ-036 VALID, stall=1 for 5 cycles, imem_ack pulsed meanwhile with rdata=32'hDEADBEEF -> instr, PC, instr_count unchanged; on stall=0 accepted once, count +1.
REQ-037 ack delayed 3 cycles -> imem_req and imem_addr stable 4 cycles, instr captured on ack edge; rst pulse during wait -> PC=RESET_PC, late ack ignored.
REQ-038 PC=32'h100, PCsrc=1, ImmOp=32'h2: with FETCH_MISALIGN_CHK_EN -> misalign_err=1, imem_req stays 0 until reset; without -> next imem_addr=32'h100, misalign_err=0.
REQ-039 RESET_PC=32'hFFFF_FFFC, PCsrc=0 accept -> next imem_addr=32'h0000_0000.
